// File: rtl/mult_dot_sequencer_pkg.sv
// Shared types and widths for the dot-product sequencer in front of the 8x8 sequential multiplier.
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        OUTPUT  = 2'd3
    } seq_state_e;

    // Two's complement add overflow: equal operand signs, result sign differs.
    function automatic logic add_overflow(input logic sign_a, input logic sign_b, input logic sign_sum);
        return (sign_a == sign_b) && (sign_sum != sign_a);
    endfunction

endpackage

// File: rtl/mult_dot_sequencer_if.sv
// Operand stream, multiplier handshake and result stream of the dot-product sequencer.
interface mult_dot_sequencer_if
    import mult_pkg::*;
#(
    parameter int ACC_W = 24
) ();

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              in_last;

    logic              mul_start;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [PROD_W-1:0] mul_product;
    logic              mul_done;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    // master is the sequencer itself; slave is the operand source, multiplier and result sink.
    modport master (
        input  in_valid, in_a, in_b, in_last, mul_product, mul_done, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_sum, out_ovf
    );

    modport slave (
        output in_valid, in_a, in_b, in_last, mul_product, mul_done, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_sum, out_ovf
    );

endinterface

// File: rtl/mult_operand_fifo.sv
// Small synchronous operand FIFO with registered pointers and occupancy count.
module mult_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees a slot, so a push is honoured even when full.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mult_dot_sequencer.sv
// Feeds buffered operand pairs to the sequential multiplier one at a time and
// accumulates the signed products into a dot-product sum with sticky overflow.
module mult_dot_sequencer
    import mult_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ACC_W = 24
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mult_dot_sequencer_if.master bus
);

    localparam int ENTRY_W = 2 * OP_W + 1;

    seq_state_e       state_reg, state_next;
    logic             mul_start_reg, mul_start_next;
    logic [OP_W-1:0]  mul_a_reg, mul_a_next;
    logic [OP_W-1:0]  mul_b_reg, mul_b_next;
    logic             last_reg, last_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             ovf_reg, ovf_next;
    logic             out_valid_reg, out_valid_next;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wr_data;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;

    assign fifo_push    = bus.in_valid && !fifo_full;
    assign fifo_wr_data = {bus.in_a, bus.in_b, bus.in_last};

    mult_operand_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign prod_ext = ACC_W'(signed'(bus.mul_product));
    assign sum      = acc_reg + prod_ext;

    always_comb begin
        state_next     = state_reg;
        mul_start_next = mul_start_reg;
        mul_a_next     = mul_a_reg;
        mul_b_next     = mul_b_reg;
        last_next      = last_reg;
        acc_next       = acc_reg;
        ovf_next       = ovf_reg;
        out_valid_next = out_valid_reg;
        fifo_pop       = 1'b0;
        case (state_reg)
            IDLE: begin
                // Never raise start while the multiplier still reports done.
                if (!fifo_empty && !bus.mul_done) begin
                    fifo_pop       = 1'b1;
                    {mul_a_next, mul_b_next, last_next} = fifo_rd_data;
                    mul_start_next = 1'b1;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mul_done) begin
                    acc_next       = sum;
                    ovf_next       = ovf_reg | add_overflow(acc_reg[ACC_W-1], prod_ext[ACC_W-1], sum[ACC_W-1]);
                    mul_start_next = 1'b0;
                    state_next     = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.mul_done) begin
                    if (last_reg) begin
                        out_valid_next = 1'b1;
                        state_next     = OUTPUT;
                    end else begin
                        state_next     = IDLE;
                    end
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    acc_next       = '0;
                    ovf_next       = 1'b0;
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_reg     <= IDLE;
            mul_start_reg <= 1'b0;
            mul_a_reg     <= '0;
            mul_b_reg     <= '0;
            last_reg      <= 1'b0;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mul_start_reg <= mul_start_next;
            mul_a_reg     <= mul_a_next;
            mul_b_reg     <= mul_b_next;
            last_reg      <= last_next;
            acc_reg       <= acc_next;
            ovf_reg       <= ovf_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.mul_start = mul_start_reg;
    assign bus.mul_a     = mul_a_reg;
    assign bus.mul_b     = mul_b_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = acc_reg;
    assign bus.out_ovf   = ovf_reg;

endmodule

// File: tb/tb_mult_dot_sequencer.sv
// Directed bench: table of dot-product vectors plus hand-written latency, backpressure,
// 16-bit overflow and mid-transaction reset sequences, with behavioural multipliers.
module tb_mult_dot_sequencer;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    mult_dot_sequencer_if #(.ACC_W(24)) bus24 ();
    mult_dot_sequencer_if #(.ACC_W(16)) bus16 ();

    mult_dot_sequencer #(.DEPTH(4), .ACC_W(24)) dut24 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus24)
    );

    mult_dot_sequencer #(.DEPTH(4), .ACC_W(16)) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mul_lat  = 1;
    int mul_hold = 0;

    function automatic logic [15:0] mul_model(input logic signed [7:0] a, input logic signed [7:0] b);
        logic signed [15:0] x;
        logic signed [15:0] y;
        x = a;
        y = b;
        return x * y;
    endfunction

    // Behavioural multiplier for the 24-bit instance; also logs each start with its operand A.
    int         cnt24 = 0, hcnt24 = 0, starts24 = 0;
    logic       start_prev24;
    logic [7:0] qa24 [$];
    always @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            bus24.mul_done    <= 1'b0;
            bus24.mul_product <= '0;
            cnt24             <= 0;
            hcnt24            <= 0;
            start_prev24      <= 1'b0;
        end else begin
            start_prev24 <= bus24.mul_start;
            if (bus24.mul_start && !start_prev24) begin
                starts24 <= starts24 + 1;
                qa24.push_back(bus24.mul_a);
            end
            if (bus24.mul_start && !bus24.mul_done) begin
                if (cnt24 >= mul_lat) begin
                    bus24.mul_done    <= 1'b1;
                    bus24.mul_product <= mul_model(bus24.mul_a, bus24.mul_b);
                    cnt24             <= 0;
                end else begin
                    cnt24 <= cnt24 + 1;
                end
            end else if (!bus24.mul_start && bus24.mul_done) begin
                if (hcnt24 >= mul_hold) begin
                    bus24.mul_done <= 1'b0;
                    hcnt24         <= 0;
                end else begin
                    hcnt24 <= hcnt24 + 1;
                end
            end
        end
    end

    int cnt16 = 0, hcnt16 = 0;
    always @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            bus16.mul_done    <= 1'b0;
            bus16.mul_product <= '0;
            cnt16             <= 0;
            hcnt16            <= 0;
        end else if (bus16.mul_start && !bus16.mul_done) begin
            if (cnt16 >= mul_lat) begin
                bus16.mul_done    <= 1'b1;
                bus16.mul_product <= mul_model(bus16.mul_a, bus16.mul_b);
                cnt16             <= 0;
            end else begin
                cnt16 <= cnt16 + 1;
            end
        end else if (!bus16.mul_start && bus16.mul_done) begin
            if (hcnt16 >= mul_hold) begin
                bus16.mul_done <= 1'b0;
                hcnt16         <= 0;
            end else begin
                hcnt16 <= hcnt16 + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, got no event, expected one", name);
    endtask

    task automatic push24(input logic [7:0] a, input logic [7:0] b, input logic l);
        int k;
        k = 0;
        @(negedge clock);
        bus24.in_valid = 1'b1;
        bus24.in_a     = a;
        bus24.in_b     = b;
        bus24.in_last  = l;
        while (!bus24.in_ready && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (!bus24.in_ready) timeout("push24");
        @(posedge clock);
    endtask

    task automatic offer24(input logic [7:0] a, input logic [7:0] b, input logic l);
        @(negedge clock);
        bus24.in_valid = 1'b1;
        bus24.in_a     = a;
        bus24.in_b     = b;
        bus24.in_last  = l;
        @(posedge clock);
    endtask

    task automatic idle24();
        @(negedge clock);
        bus24.in_valid = 1'b0;
    endtask

    task automatic wait_valid24(input string name);
        int k;
        k = 0;
        while (!bus24.out_valid && k < 500) begin
            @(negedge clock);
            k++;
        end
        if (!bus24.out_valid) timeout(name);
    endtask

    task automatic accept24(input string name);
        @(negedge clock);
        bus24.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus24.out_ready = 1'b0;
        check(name, 32'(bus24.out_valid), 32'd0);
    endtask

    task automatic push16(input logic [7:0] a, input logic [7:0] b, input logic l);
        int k;
        k = 0;
        @(negedge clock);
        bus16.in_valid = 1'b1;
        bus16.in_a     = a;
        bus16.in_b     = b;
        bus16.in_last  = l;
        while (!bus16.in_ready && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (!bus16.in_ready) timeout("push16");
        @(posedge clock);
        @(negedge clock);
        bus16.in_valid = 1'b0;
    endtask

    task automatic result16(input string name, input logic [15:0] exp_sum, input logic exp_ovf);
        int k;
        k = 0;
        while (!bus16.out_valid && k < 500) begin
            @(negedge clock);
            k++;
        end
        if (!bus16.out_valid) timeout(name);
        check({name, "_sum"}, 32'(bus16.out_sum), 32'(exp_sum));
        check({name, "_ovf"}, 32'(bus16.out_ovf), 32'(exp_ovf));
        bus16.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus16.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        last;
        logic [23:0] exp_sum;
        logic        exp_ovf;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs [8];
    int   pairs;
    int   base_starts;
    logic [23:0] held_sum;

    initial begin
        vecs[0] = '{8'hFE, 8'h05, 1'b1, 24'hFFFFF6, 1'b0, 1, 0};
        vecs[1] = '{8'h01, 8'h02, 1'b0, 24'h000000, 1'b0, 0, 2};
        vecs[2] = '{8'h03, 8'h04, 1'b0, 24'h000000, 1'b0, 2, 0};
        vecs[3] = '{8'h05, 8'h06, 1'b1, 24'h00002C, 1'b0, 3, 1};
        vecs[4] = '{8'h02, 8'h02, 1'b1, 24'h000004, 1'b0, 1, 3};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 24'h004000, 1'b0, 0, 0};
        vecs[6] = '{8'h7F, 8'h81, 1'b1, 24'hFFC0FF, 1'b0, 2, 1};
        vecs[7] = '{8'h00, 8'h55, 1'b1, 24'h000000, 1'b0, 1, 0};

        bus24.in_valid = 1'b0; bus24.in_a = '0; bus24.in_b = '0; bus24.in_last = 1'b0; bus24.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_last = 1'b0; bus16.out_ready = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_in_ready",  32'(bus24.in_ready),  32'd1);
        check("rst_mul_start", 32'(bus24.mul_start), 32'd0);
        check("rst_mul_a",     32'(bus24.mul_a),     32'd0);
        check("rst_mul_b",     32'(bus24.mul_b),     32'd0);
        check("rst_out_valid", 32'(bus24.out_valid), 32'd0);
        check("rst_out_sum",   32'(bus24.out_sum),   32'd0);
        check("rst_out_ovf",   32'(bus24.out_ovf),   32'd0);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);

        // First push: start is low one cycle later and high two cycles later.
        base_starts = starts24;
        push24(8'd3, 8'd4, 1'b1);
        idle24();
        check("lat_start_c1", 32'(bus24.mul_start), 32'd0);
        @(negedge clock);
        check("lat_start_c2", 32'(bus24.mul_start), 32'd1);
        check("lat_mul_a",    32'(bus24.mul_a),     32'd3);
        check("lat_mul_b",    32'(bus24.mul_b),     32'd4);
        wait_valid24("first_valid");
        check("first_sum",    32'(bus24.out_sum),   32'd12);
        check("first_ovf",    32'(bus24.out_ovf),   32'd0);
        check("first_starts", 32'(starts24 - base_starts), 32'd1);
        accept24("first_accept");

        pairs = 0;
        base_starts = starts24;
        for (int i = 0; i < 8; i++) begin
            mul_lat  = vecs[i].lat;
            mul_hold = vecs[i].hold;
            push24(vecs[i].a, vecs[i].b, vecs[i].last);
            pairs++;
            if (vecs[i].last) begin
                idle24();
                wait_valid24($sformatf("vec%0d_valid", i));
                check($sformatf("vec%0d_sum", i),    32'(bus24.out_sum), 32'(vecs[i].exp_sum));
                check($sformatf("vec%0d_ovf", i),    32'(bus24.out_ovf), 32'(vecs[i].exp_ovf));
                check($sformatf("vec%0d_starts", i), 32'(starts24 - base_starts), 32'(pairs));
                accept24($sformatf("vec%0d_accept", i));
                pairs = 0;
                base_starts = starts24;
            end
        end

        // Backpressure: result stalled, four pairs fill the FIFO, a fifth is refused.
        mul_lat  = 1;
        mul_hold = 0;
        push24(8'd1, 8'd1, 1'b1);
        idle24();
        wait_valid24("bp_first_valid");
        qa24.delete();
        base_starts = starts24;
        for (int i = 1; i <= 4; i++) begin
            offer24(8'(i), 8'(i), (i == 4));
            #1;
            check($sformatf("bp_in_ready_after_%0d", i), 32'(bus24.in_ready), (i == 4) ? 32'd0 : 32'd1);
        end
        offer24(8'd9, 8'd9, 1'b1);
        idle24();
        repeat (3) @(negedge clock);
        check("bp_no_start",   32'(bus24.mul_start), 32'd0);
        check("bp_valid_held", 32'(bus24.out_valid), 32'd1);
        check("bp_sum_held",   32'(bus24.out_sum),   32'd1);
        accept24("bp_accept_first");
        wait_valid24("bp_second_valid");
        check("bp_sum",    32'(bus24.out_sum), 32'd30);
        check("bp_starts", 32'(starts24 - base_starts), 32'd4);
        check("bp_order_n", 32'(qa24.size()), 32'd4);
        for (int i = 0; i < 4 && i < qa24.size(); i++) begin
            check($sformatf("bp_order_%0d", i), 32'(qa24[i]), 32'(i + 1));
        end
        accept24("bp_accept_second");
        repeat (40) @(negedge clock);
        check("bp_fifth_dropped", 32'(bus24.out_valid), 32'd0);

        // 16-bit accumulator: 3 x 16129 wraps to 0xBD03 with overflow; next sum starts clean.
        push16(8'd127, 8'd127, 1'b0);
        push16(8'd127, 8'd127, 1'b0);
        push16(8'd127, 8'd127, 1'b1);
        result16("acc16_wrap", 16'hBD03, 1'b1);
        push16(8'd1, 8'd1, 1'b1);
        result16("acc16_clean", 16'h0001, 1'b0);

        // Reset in ISSUE: outputs fall immediately, then a fresh transaction still works.
        mul_lat = 6;
        push24(8'd3, 8'd4, 1'b1);
        idle24();
        for (int k = 0; k < 20 && !bus24.mul_start; k++) @(negedge clock);
        check("rst_mid_in_issue", 32'(bus24.mul_start), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_mid_start", 32'(bus24.mul_start), 32'd0);
        check("rst_mid_valid", 32'(bus24.out_valid), 32'd0);
        check("rst_mid_ready", 32'(bus24.in_ready),  32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        mul_lat = 1;
        push24(8'd3, 8'd4, 1'b1);
        idle24();
        wait_valid24("post_rst_valid");
        check("post_rst_sum", 32'(bus24.out_sum), 32'd12);
        accept24("post_rst_accept");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
